edit_cmd_ctrl: RTL and testbench

- Byte-stream command controller for the line editor.
- Consumes received bytes (one-cycle priem strobe plus rx_byte), parses single-byte controls and ESC/CSI sequences with an FSM, and tracks cursor position and line length.
- Issues one edit command at a time to the downstream line buffer over a valid/ready handshake.
- Replaces fixed-delay decoding of the last four received bytes with explicit sequencing, timeout and bounds checks.

---
 rtl/cmd_pkg.sv | 40 ++++
 rtl/cursor_track.sv | 60 ++++++
 rtl/edit_cmd_ctrl.sv | 156 +++++++++++++++
 tb/tb_edit_cmd_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared types and byte constants for the line-editor command controller.
package cmd_pkg;

    // Edit command codes issued to the line buffer
    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_INS      = 3'd1,
        OP_LEFT     = 3'd2,
        OP_RIGHT    = 3'd3,
        OP_DEL_BACK = 3'd4,
        OP_DEL_FWD  = 3'd5,
        OP_ENTER    = 3'd6
    } op_t;

    // Parser states: plain bytes, after ESC, after ESC '[', after ESC '[' '3'
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ESC  = 2'd1,
        CSI  = 2'd2,
        CSI3 = 2'd3
    } state_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_LBR   = 8'h5B;
    localparam logic [7:0] CH_TILDE = 8'h7E;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_D     = 8'h44;
    localparam logic [7:0] CH_3     = 8'h33;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/cursor_track.sv
// Cursor position / line length bookkeeping with a legality check for a
// candidate command. Registers only move on a handshake transfer.
module cursor_track
    import cmd_pkg::*;
#(
    parameter int LINE_LEN = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  op_t                           chk_op,
    output logic                          chk_ok,
    input  logic                          xfer,
    input  op_t                           xfer_op,
    output logic [$clog2(LINE_LEN+1)-1:0] pos,
    output logic [$clog2(LINE_LEN+1)-1:0] len
);

    localparam int PW = $clog2(LINE_LEN + 1);
    localparam logic [PW-1:0] MAX_LEN = PW'(LINE_LEN);

    // Would the candidate op keep 0 <= pos <= len <= LINE_LEN?
    always_comb begin
        chk_ok = 1'b0;
        case (chk_op)
            OP_INS:                 chk_ok = (len < MAX_LEN);
            OP_LEFT, OP_DEL_BACK:   chk_ok = (pos != '0);
            OP_RIGHT, OP_DEL_FWD:   chk_ok = (pos < len);
            OP_ENTER:               chk_ok = 1'b1;
            default:                chk_ok = 1'b0;
        endcase
    end

    // Apply the accepted command's effect on the transfer edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos <= '0;
            len <= '0;
        end else if (xfer) begin
            case (xfer_op)
                OP_INS: begin
                    pos <= pos + 1'b1;
                    len <= len + 1'b1;
                end
                OP_LEFT:  pos <= pos - 1'b1;
                OP_RIGHT: pos <= pos + 1'b1;
                OP_DEL_BACK: begin
                    pos <= pos - 1'b1;
                    len <= len - 1'b1;
                end
                OP_DEL_FWD: len <= len - 1'b1;
                OP_ENTER: begin
                    pos <= '0;
                    len <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/edit_cmd_ctrl.sv
// Byte-stream command controller: parses control bytes and ESC/CSI
// sequences, bound-checks the resulting edit op and hands it to the line
// buffer over a valid/ready handshake, one command at a time.
module edit_cmd_ctrl
    import cmd_pkg::*;
#(
    parameter int LINE_LEN    = 64,
    parameter int ESC_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          priem,
    input  logic [7:0]                    rx_byte,
    input  logic                          right_from_gate,
    input  logic                          buf_ready,
    output logic                          cmd_valid,
    output op_t                           cmd_op,
    output logic [7:0]                    cmd_char,
    output logic [$clog2(LINE_LEN+1)-1:0] cursor_pos,
    output logic [$clog2(LINE_LEN+1)-1:0] line_len,
    output logic                          overrun,
    output logic                          reject
);

    localparam int TW = (ESC_TIMEOUT > 2) ? $clog2(ESC_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(ESC_TIMEOUT - 1);

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic          gate_pend;

    logic          dec_hit;
    op_t           dec_op;
    logic [7:0]    dec_char;
    logic          gate_srv;
    logic          chk_ok;
    logic          xfer;

    assign xfer = cmd_valid & buf_ready;

    cursor_track #(
        .LINE_LEN (LINE_LEN)
    ) u_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .chk_op  (dec_op),
        .chk_ok  (chk_ok),
        .xfer    (xfer),
        .xfer_op (cmd_op),
        .pos     (cursor_pos),
        .len     (line_len)
    );

    // Decode the accepted byte (or a pending gate request) into next state and a candidate op
    always_comb begin
        state_nx = state;
        dec_hit  = 1'b0;
        dec_op   = OP_NOP;
        dec_char = 8'h00;
        gate_srv = 1'b0;
        if (priem && !cmd_valid) begin
            case (state)
                IDLE: begin
                    if (is_printable(rx_byte)) begin
                        dec_hit  = 1'b1;
                        dec_op   = OP_INS;
                        dec_char = rx_byte;
                    end else if (rx_byte == CH_BS) begin
                        dec_hit = 1'b1;
                        dec_op  = OP_DEL_BACK;
                    end else if (rx_byte == CH_CR) begin
                        dec_hit = 1'b1;
                        dec_op  = OP_ENTER;
                    end else if (rx_byte == CH_ESC) begin
                        state_nx = ESC;
                    end
                end
                ESC: begin
                    if (rx_byte == CH_LBR)      state_nx = CSI;
                    else if (rx_byte == CH_ESC) state_nx = ESC;
                    else                        state_nx = IDLE;
                end
                CSI: begin
                    state_nx = IDLE;
                    if (rx_byte == CH_D) begin
                        dec_hit = 1'b1;
                        dec_op  = OP_LEFT;
                    end else if (rx_byte == CH_C || rx_byte == CH_A) begin
                        dec_hit = 1'b1;
                        dec_op  = OP_RIGHT;
                    end else if (rx_byte == CH_3) begin
                        state_nx = CSI3;
                    end else if (rx_byte == CH_ESC) begin
                        state_nx = ESC;
                    end
                end
                CSI3: begin
                    state_nx = IDLE;
                    if (rx_byte == CH_TILDE) begin
                        dec_hit = 1'b1;
                        dec_op  = OP_DEL_FWD;
                    end else if (rx_byte == CH_ESC) begin
                        state_nx = ESC;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (!priem && state != IDLE && timer == T_LAST) begin
            // Stale escape sequence: drop it silently
            state_nx = IDLE;
        end else if (!priem && state == IDLE && !cmd_valid && gate_pend) begin
            gate_srv = 1'b1;
            dec_hit  = 1'b1;
            dec_op   = OP_RIGHT;
        end
    end

    // Parser state, escape timer, gate flag, handshake and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            gate_pend <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NOP;
            cmd_char  <= 8'h00;
            overrun   <= 1'b0;
            reject    <= 1'b0;
        end else begin
            state <= state_nx;

            if (priem || state == IDLE || state_nx == IDLE) timer <= '0;
            else                                             timer <= timer + 1'b1;

            // A request arriving while one is already pending is lost
            if (gate_srv)             gate_pend <= 1'b0;
            else if (right_from_gate) gate_pend <= 1'b1;

            overrun <= priem & cmd_valid;
            reject  <= dec_hit & ~chk_ok;

            if (cmd_valid) begin
                if (buf_ready) begin
                    cmd_valid <= 1'b0;
                    cmd_op    <= OP_NOP;
                    cmd_char  <= 8'h00;
                end
            end else if (dec_hit && chk_ok) begin
                cmd_valid <= 1'b1;
                cmd_op    <= dec_op;
                cmd_char  <= dec_char;
            end
        end
    end

endmodule

// File: tb/tb_edit_cmd_ctrl.sv
// Bench for edit_cmd_ctrl: directed scenarios followed by random byte
// traffic, checked against a sequence-matching model of the editor.
module tb_edit_cmd_ctrl;

    localparam int LINE_LEN    = 8;
    localparam int ESC_TIMEOUT = 16;
    localparam int PW          = $clog2(LINE_LEN + 1);

    localparam int M_INS = 1, M_LEFT = 2, M_RIGHT = 3, M_DEL_BACK = 4,
                   M_DEL_FWD = 5, M_ENTER = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          priem = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          right_from_gate = 1'b0;
    logic          buf_ready = 1'b0;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [7:0]    cmd_char;
    logic [PW-1:0] cursor_pos;
    logic [PW-1:0] line_len;
    logic          overrun;
    logic          reject;

    int checks = 0;
    int failures = 0;

    // Model: editor line as (pos,len), unfinished escape bytes in a queue
    int         m_pos = 0;
    int         m_len = 0;
    logic [7:0] m_seq[$];
    int         m_pend_op = 0;

    edit_cmd_ctrl #(
        .LINE_LEN    (LINE_LEN),
        .ESC_TIMEOUT (ESC_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .priem           (priem),
        .rx_byte         (rx_byte),
        .right_from_gate (right_from_gate),
        .buf_ready       (buf_ready),
        .cmd_valid       (cmd_valid),
        .cmd_op          (cmd_op),
        .cmd_char        (cmd_char),
        .cursor_pos      (cursor_pos),
        .line_len        (line_len),
        .overrun         (overrun),
        .reject          (reject)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input int op);
        case (op)
            M_INS:                return m_len < LINE_LEN;
            M_LEFT, M_DEL_BACK:   return m_pos > 0;
            M_RIGHT, M_DEL_FWD:   return m_pos < m_len;
            M_ENTER:              return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    task automatic m_apply(input int op);
        case (op)
            M_INS:      begin m_pos++; m_len++; end
            M_LEFT:     m_pos--;
            M_RIGHT:    m_pos++;
            M_DEL_BACK: begin m_pos--; m_len--; end
            M_DEL_FWD:  m_len--;
            M_ENTER:    begin m_pos = 0; m_len = 0; end
            default: ;
        endcase
    endtask

    // Byte-level model of the command language
    task automatic m_byte(input logic [7:0] b, output bit hit, output int op, output logic [7:0] chr);
        int n;
        hit = 1'b0; op = 0; chr = 8'h00;
        if (m_seq.size() == 0) begin
            if (b >= 8'h20 && b <= 8'h7E) begin hit = 1'b1; op = M_INS; chr = b; end
            else if (b == 8'h08) begin hit = 1'b1; op = M_DEL_BACK; end
            else if (b == 8'h0D) begin hit = 1'b1; op = M_ENTER; end
            else if (b == 8'h1B) m_seq.push_back(b);
        end else if (b == 8'h1B) begin
            m_seq.delete();
            m_seq.push_back(b);
        end else begin
            m_seq.push_back(b);
            n = m_seq.size();
            if (n == 2 && b == 8'h5B) ;
            else if (n == 3 && b == 8'h33) ;
            else begin
                if (n == 3 && b == 8'h44) begin hit = 1'b1; op = M_LEFT; end
                else if (n == 3 && (b == 8'h43 || b == 8'h41)) begin hit = 1'b1; op = M_RIGHT; end
                else if (n == 4 && b == 8'h7E) begin hit = 1'b1; op = M_DEL_FWD; end
                m_seq.delete();
            end
        end
    endtask

    task automatic chk_pos_len(input string tag);
        chk({tag, "_pos"}, 32'(cursor_pos), m_pos);
        chk({tag, "_len"}, 32'(line_len), m_len);
    endtask

    // Send one byte (optionally with a coincident gate request); leaves any command pending
    task automatic send(input logic [7:0] b, input bit gate, output bit issued);
        bit         hit;
        int         op;
        logic [7:0] chr;
        bit         ok;
        m_byte(b, hit, op, chr);
        ok = hit && m_legal(op);
        @(negedge clk);
        priem = 1'b1; rx_byte = b; right_from_gate = gate;
        @(negedge clk);
        priem = 1'b0; right_from_gate = 1'b0;
        chk("valid", 32'(cmd_valid), 32'(ok));
        chk("reject", 32'(reject), 32'(hit && !ok));
        if (ok) begin
            chk("op", 32'(cmd_op), op);
            chk("char", 32'(cmd_char), 32'(chr));
            m_pend_op = op;
        end
        issued = ok;
    endtask

    // Hold off for a few cycles, then accept the pending command
    task automatic ack_cmd(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(cmd_valid), 1);
            chk("hold_op", 32'(cmd_op), m_pend_op);
        end
        buf_ready = 1'b1;
        @(negedge clk);
        buf_ready = 1'b0;
        m_apply(m_pend_op);
        chk("xfer_valid", 32'(cmd_valid), 0);
        chk_pos_len("xfer");
    endtask

    task automatic send_ack(input logic [7:0] b, input int hold);
        bit issued;
        send(b, 1'b0, issued);
        if (issued) ack_cmd(hold);
        else chk_pos_len("norx");
    endtask

    // Check the cycle in which a pending gate request is served
    task automatic gate_served();
        bit ok;
        ok = m_legal(M_RIGHT);
        @(negedge clk);
        chk("gate_valid", 32'(cmd_valid), 32'(ok));
        chk("gate_reject", 32'(reject), 32'(!ok));
        if (ok) begin
            chk("gate_op", 32'(cmd_op), M_RIGHT);
            m_pend_op = M_RIGHT;
            ack_cmd(1);
        end
    endtask

    initial begin
        bit         issued;
        logic [7:0] b;
        int         r;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_op", 32'(cmd_op), 0);
        chk("rst_char", 32'(cmd_char), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_reject", 32'(reject), 0);
        chk_pos_len("rst");
        rst_n = 1'b1;

        // Plain inserts
        send_ack(8'h61, 0);
        send_ack(8'h62, 1);
        send_ack(8'h63, 2);
        chk("t1_pos", 32'(cursor_pos), 3);
        chk("t1_len", 32'(line_len), 3);

        // Cursor left, then forward delete
        send_ack(8'h1B, 0); send_ack(8'h5B, 0); send_ack(8'h44, 0);
        chk("t2_left_pos", 32'(cursor_pos), 2);
        send_ack(8'h1B, 0); send_ack(8'h5B, 0); send_ack(8'h33, 0); send_ack(8'h7E, 0);
        chk("t2_del_pos", 32'(cursor_pos), 2);
        chk("t2_del_len", 32'(line_len), 2);

        // Bound rejects on an empty line
        send_ack(8'h0D, 0);
        send_ack(8'h08, 0);
        @(negedge clk);
        chk("rej_pulse_end", 32'(reject), 0);
        send_ack(8'h1B, 0); send_ack(8'h5B, 0); send_ack(8'h43, 0);
        chk("t3_pos", 32'(cursor_pos), 0);

        // Escape timeout: the late 'D' is plain text
        send_ack(8'h1B, 0);
        repeat (ESC_TIMEOUT + 2) @(negedge clk);
        m_seq.delete();
        send_ack(8'h44, 0);
        chk("t4_len", 32'(line_len), 1);
        // Slow but in-time sequence still completes
        send_ack(8'h1B, 0);
        repeat (ESC_TIMEOUT - 5) @(negedge clk);
        send_ack(8'h5B, 0); send_ack(8'h44, 0);
        chk("t4_slow_left", 32'(cursor_pos), 0);

        // Overrun while a command is outstanding
        send(8'h65, 1'b0, issued);
        priem = 1'b1; rx_byte = 8'h66;
        @(negedge clk);
        priem = 1'b0;
        chk("ovr_pulse", 32'(overrun), 1);
        chk("ovr_valid", 32'(cmd_valid), 1);
        chk("ovr_char", 32'(cmd_char), 32'h65);
        @(negedge clk);
        chk("ovr_pulse_end", 32'(overrun), 0);
        ack_cmd(0);
        @(negedge clk);
        chk("ovr_single", 32'(cmd_valid), 0);
        chk_pos_len("ovr");

        // Gate request coinciding with a byte: byte first, then RIGHT
        send(8'h78, 1'b1, issued);
        ack_cmd(0);
        gate_served();
        send_ack(8'h0D, 0);
        send(8'h78, 1'b1, issued);
        ack_cmd(1);
        gate_served();
        send_ack(8'h1B, 0); send_ack(8'h5B, 0); send_ack(8'h44, 0);
        @(negedge clk);
        right_from_gate = 1'b1;
        @(negedge clk);
        right_from_gate = 1'b0;
        gate_served();

        // Full line rejects inserts; ENTER clears
        send_ack(8'h0D, 0);
        for (int i = 0; i < LINE_LEN; i++) send_ack(8'(32 + $urandom_range(0, 94)), 0);
        chk("full_len", 32'(line_len), LINE_LEN);
        send_ack(8'h5A, 0);
        chk("full_len_kept", 32'(line_len), LINE_LEN);
        send_ack(8'h0D, 0);
        chk("enter_pos", 32'(cursor_pos), 0);
        chk("enter_len", 32'(line_len), 0);

        // Reset mid-sequence abandons it
        send_ack(8'h61, 0);
        send_ack(8'h1B, 0); send_ack(8'h5B, 0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_seq.delete(); m_pos = 0; m_len = 0;
        chk_pos_len("midrst");
        send_ack(8'h44, 0);
        chk("midrst_ins", 32'(line_len), 1);

        // Random byte traffic
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1, 2, 3, 4: b = 8'(32 + $urandom_range(0, 94));
                5:  b = 8'h08;
                6:  b = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'h08;
                7, 8: b = 8'h1B;
                9:  b = 8'h5B;
                10: b = 8'h44;
                11: b = 8'h43;
                12: b = 8'h41;
                13: b = 8'h33;
                14: b = 8'h7E;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_ack(b, $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("inv", 32'((cursor_pos <= line_len) && (line_len <= LINE_LEN)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
